// File: rtl/rv_go_lsu.sv
// RV_GO load/store unit: latches one core data access, runs it on a req/ack bus
// with a timeout, and returns formatted load data with a one-cycle done pulse.
module rv_go_lsu #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        core_req,
    input  logic        core_we,
    input  logic [2:0]  core_op,
    input  logic [31:0] core_addr,
    input  logic [31:0] core_wdata,
    output logic [31:0] core_rdata,
    output logic        core_done,
    output logic        core_err,
    output logic        core_stall,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    // state | meaning
    // IDLE  | waiting for core_req; decodes and either issues a bus cycle or errors out
    // BUS   | bus_req held with stable bus_* outputs until bus_ack or timeout
    // DONE  | one-cycle core_done pulse with core_err / core_rdata
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    state_t      state_q;
    logic [15:0] cnt_q;
    logic [1:0]  lo_q;
    logic [2:0]  op_q;
    logic        done_q;
    logic        err_q;
    logic [31:0] rdata_q;
    logic        bus_req_q;
    logic        bus_we_q;
    logic [31:0] bus_addr_q;
    logic [3:0]  bus_be_q;
    logic [31:0] bus_wdata_q;

    logic        op_ill;
    logic        mis_d;
    logic [3:0]  be_d;
    logic [31:0] wdata_d;

    always_comb begin
        op_ill  = core_we ? (core_op > 3'b010)
                          : (core_op == 3'b011 || core_op[2:1] == 2'b11);
        mis_d   = 1'b0;
        be_d    = 4'b0000;
        wdata_d = 32'd0;
        case (core_op[1:0])
            2'b00: begin
                be_d    = 4'b0001 << core_addr[1:0];
                wdata_d = {4{core_wdata[7:0]}};
            end
            2'b01: begin
                mis_d   = core_addr[0];
                be_d    = core_addr[1] ? 4'b1100 : 4'b0011;
                wdata_d = {2{core_wdata[15:0]}};
            end
            2'b10: begin
                mis_d   = core_addr[1:0] != 2'b00;
                be_d    = 4'b1111;
                wdata_d = core_wdata;
            end
            default: ;
        endcase
        if (!core_we) begin
            wdata_d = 32'd0;
        end
    end

    function automatic logic [31:0] fmt_load(input logic [2:0] op, input logic [1:0] lo,
                                             input logic [31:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        case (lo)
            2'b00:   b = d[7:0];
            2'b01:   b = d[15:8];
            2'b10:   b = d[23:16];
            default: b = d[31:24];
        endcase
        h = lo[1] ? d[31:16] : d[15:0];
        case (op)
            3'b000:  fmt_load = {{24{b[7]}}, b};
            3'b001:  fmt_load = {{16{h[15]}}, h};
            3'b100:  fmt_load = {24'd0, b};
            3'b101:  fmt_load = {16'd0, h};
            default: fmt_load = d;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 16'd0;
            lo_q        <= 2'b00;
            op_q        <= 3'b000;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= 32'd0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'd0;
            bus_be_q    <= 4'b0000;
            bus_wdata_q <= 32'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (core_req) begin
                        lo_q <= core_addr[1:0];
                        op_q <= core_op;
                        if (op_ill || mis_d) begin
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                            rdata_q <= 32'd0;
                            state_q <= S_DONE;
                        end else begin
                            bus_req_q   <= 1'b1;
                            bus_we_q    <= core_we;
                            bus_addr_q  <= {core_addr[31:2], 2'b00};
                            bus_be_q    <= be_d;
                            bus_wdata_q <= wdata_d;
                            cnt_q       <= 16'd0;
                            state_q     <= S_BUS;
                        end
                    end
                end
                S_BUS: begin
                    // an ack arriving on the timeout cycle still completes the access
                    if (bus_ack) begin
                        bus_req_q <= 1'b0;
                        done_q    <= 1'b1;
                        err_q     <= 1'b0;
                        rdata_q   <= bus_we_q ? 32'd0 : fmt_load(op_q, lo_q, bus_rdata);
                        state_q   <= S_DONE;
                    end else if (cnt_q == CNT_LAST) begin
                        bus_req_q <= 1'b0;
                        done_q    <= 1'b1;
                        err_q     <= 1'b1;
                        rdata_q   <= 32'd0;
                        state_q   <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    err_q   <= 1'b0;
                    rdata_q <= 32'd0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign core_stall = (state_q == S_IDLE && core_req) || state_q == S_BUS;
    assign core_done  = done_q;
    assign core_err   = err_q;
    assign core_rdata = rdata_q;
    assign bus_req    = bus_req_q;
    assign bus_we     = bus_we_q;
    assign bus_addr   = bus_addr_q;
    assign bus_be     = bus_be_q;
    assign bus_wdata  = bus_wdata_q;

endmodule

// File: tb/tb_rv_go_lsu.sv
// Bench for rv_go_lsu: transaction-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized accesses.
module tb_rv_go_lsu;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        core_req, core_we;
    logic [2:0]  core_op;
    logic [31:0] core_addr, core_wdata;
    logic [31:0] core_rdata;
    logic        core_done, core_err, core_stall;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    rv_go_lsu #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .core_req(core_req), .core_we(core_we), .core_op(core_op),
        .core_addr(core_addr), .core_wdata(core_wdata),
        .core_rdata(core_rdata), .core_done(core_done), .core_err(core_err),
        .core_stall(core_stall),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // expected outputs for the current cycle
    logic        m_busreq = 0, m_we = 0, m_done = 0, m_err = 0, m_stall = 0;
    logic [31:0] m_addr = 0, m_wdata = 0, m_rdata = 0;
    logic [3:0]  m_be = 0;

    // values captured by the last access, for literal checks
    logic [31:0] cap_addr, cap_wdata, cap_rdata;
    logic [3:0]  cap_be;
    logic        cap_we, cap_done, cap_err;
    int          cap_nreq, cap_lat;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int acc_bytes(input logic [2:0] op);
        int k = int'(op) % 4;
        return (k == 0) ? 1 : (k == 1) ? 2 : 4;
    endfunction

    function automatic logic exp_err(input logic we, input logic [2:0] op, input logic [31:0] addr);
        logic ill = we ? (op > 2) : (op == 3 || op == 6 || op == 7);
        return ill || ((addr % acc_bytes(op)) != 0);
    endfunction

    function automatic logic [3:0] exp_be(input logic [2:0] op, input logic [31:0] addr);
        int n = acc_bytes(op);
        int v = ((1 << n) - 1) << (addr % 4);
        return v[3:0];
    endfunction

    function automatic logic [31:0] exp_wdata(input logic we, input logic [2:0] op,
                                              input logic [31:0] wd);
        logic [31:0] r = 0;
        int n = acc_bytes(op);
        if (we) for (int k = 0; k < 4; k++) r[8*k +: 8] = wd[8*(k % n) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] exp_rdata(input logic we, input logic [2:0] op,
                                              input logic [31:0] addr, input logic [31:0] rd);
        int n = acc_bytes(op);
        logic [31:0] mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 1);
        logic [31:0] v = (rd >> (8 * (addr % 4))) & mask;
        if (we) return 32'd0;
        if (op < 4 && n < 4 && v[8*n-1]) v = v | ~mask;
        return v;
    endfunction

    always @(negedge clk) begin
        check("bus_req", {31'd0, bus_req}, {31'd0, m_busreq});
        check("core_done", {31'd0, core_done}, {31'd0, m_done});
        check("core_err", {31'd0, core_err}, {31'd0, m_done & m_err});
        check("core_rdata", core_rdata, m_done ? m_rdata : 32'd0);
        check("core_stall", {31'd0, core_stall}, {31'd0, m_stall});
        if (m_busreq) begin
            check("bus_we", {31'd0, bus_we}, {31'd0, m_we});
            check("bus_addr", bus_addr, m_addr);
            check("bus_be", {28'd0, bus_be}, {28'd0, m_be});
            check("bus_wdata", bus_wdata, m_wdata);
        end
    end

    task automatic model_idle();
        m_busreq = 0; m_done = 0; m_err = 0; m_rdata = 0; m_stall = 0;
    endtask

    task automatic scramble_core();
        core_we = 1'($urandom); core_op = 3'($urandom);
        core_addr = $urandom; core_wdata = $urandom;
    endtask

    // Called #1 after a rising edge with the DUT idle. ack_dly: BUS cycle index
    // carrying bus_ack (>= TO means never). abort: BUS cycle index in which
    // reset is pulsed (-1 for none).
    task automatic access(input logic we, input logic [2:0] op, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] rd,
                          input int ack_dly, input int abort);
        logic e = exp_err(we, op, addr);
        cap_nreq = 0;
        cap_lat  = 1;
        core_req = 1; core_we = we; core_op = op; core_addr = addr; core_wdata = wd;
        bus_ack = 1'($urandom); bus_rdata = $urandom;
        m_stall = 1;
        @(posedge clk); #1;
        if (e) begin
            m_done = 1; m_err = 1; m_rdata = 0; m_stall = 0;
        end else begin
            m_busreq = 1; m_we = we; m_addr = addr & 32'hFFFF_FFFC;
            m_be = exp_be(op, addr); m_wdata = exp_wdata(we, op, wd); m_stall = 1;
            cap_addr = bus_addr; cap_be = bus_be; cap_wdata = bus_wdata; cap_we = bus_we;
            for (int i = 0; i < TO; i++) begin
                if (bus_req) cap_nreq++;
                bus_ack = (i == ack_dly);
                bus_rdata = (i == ack_dly) ? rd : $urandom;
                if ($urandom_range(0, 1) == 1) begin
                    scramble_core();
                    core_req = 1'($urandom);
                end
                if (i == abort) begin
                    #1 rst = 0;
                    core_req = 0; bus_ack = 0;
                    model_idle();
                    #1;
                    check("abort_bus_req", {31'd0, bus_req}, 32'd0);
                    check("abort_done", {31'd0, core_done}, 32'd0);
                    @(posedge clk); #1;
                    check("abort_no_done", {31'd0, core_done}, 32'd0);
                    @(posedge clk); #1;
                    rst = 1;
                    return;
                end
                @(posedge clk); #1;
                cap_lat++;
                if (i == ack_dly || i == TO - 1) begin
                    m_busreq = 0; m_done = 1; m_err = (i != ack_dly);
                    m_rdata = (i != ack_dly) ? 32'd0 : exp_rdata(we, op, addr, rd);
                    m_stall = 0;
                    break;
                end
            end
        end
        cap_done = core_done; cap_err = core_err; cap_rdata = core_rdata;
        // DONE cycle: core inputs and bus_ack must be ignored
        core_req = 1'($urandom); scramble_core(); bus_ack = 1'($urandom);
        @(posedge clk); #1;
        model_idle();
        core_req = 0; bus_ack = 0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            core_req = 0; bus_ack = 1'($urandom); bus_rdata = $urandom; scramble_core();
            @(posedge clk); #1;
        end
        bus_ack = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        we;
        logic [2:0]  op;
        logic [31:0] addr;
        rst = 0; core_req = 0; core_we = 0; core_op = 0; core_addr = 0; core_wdata = 0;
        bus_ack = 0; bus_rdata = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1;
        check("rst_done", {31'd0, core_done}, 32'd0);
        check("rst_bus_req", {31'd0, bus_req}, 32'd0);
        check("rst_bus_addr", bus_addr, 32'd0);
        idle_cycles(2);

        access(0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, -1);
        check("lw_addr", cap_addr, 32'h100);
        check("lw_be", {28'd0, cap_be}, 32'hF);
        check("lw_we", {31'd0, cap_we}, 32'd0);
        check("lw_lat", cap_lat, 2);
        check("lw_done", {31'd0, cap_done}, 32'd1);
        check("lw_rdata", cap_rdata, 32'hDEADBEEF);
        check("lw_err", {31'd0, cap_err}, 32'd0);

        access(0, 3'b000, 32'h103, 32'h0, 32'h80123456, 0, -1);
        check("lb_rdata", cap_rdata, 32'hFFFFFF80);
        access(0, 3'b100, 32'h103, 32'h0, 32'h80123456, 0, -1);
        check("lbu_rdata", cap_rdata, 32'h00000080);
        access(0, 3'b001, 32'h102, 32'h0, 32'h80011234, 0, -1);
        check("lh_rdata", cap_rdata, 32'hFFFF8001);
        check("lh_be", {28'd0, cap_be}, 32'hC);

        access(1, 3'b000, 32'h201, 32'h12345678, 32'h0, 3, -1);
        check("sb_addr", cap_addr, 32'h200);
        check("sb_be", {28'd0, cap_be}, 32'h2);
        check("sb_wdata", cap_wdata, 32'h78787878);
        check("sb_we", {31'd0, cap_we}, 32'd1);
        check("sb_nreq", cap_nreq, 4);
        check("sb_err", {31'd0, cap_err}, 32'd0);

        access(1, 3'b010, 32'h002, 32'h1, 32'h0, 0, -1);
        check("sw_mis_err", {31'd0, cap_err}, 32'd1);
        check("sw_mis_lat", cap_lat, 1);
        access(0, 3'b001, 32'h001, 32'h0, 32'h0, 0, -1);
        check("lh_mis_err", {31'd0, cap_err}, 32'd1);
        access(0, 3'b011, 32'h100, 32'h0, 32'h0, 0, -1);
        check("ill_op_err", {31'd0, cap_err}, 32'd1);

        access(0, 3'b010, 32'h300, 32'h0, 32'h0, 99, -1);
        check("to_nreq", cap_nreq, 4);
        check("to_err", {31'd0, cap_err}, 32'd1);
        check("to_rdata", cap_rdata, 32'd0);
        access(0, 3'b010, 32'h304, 32'h0, 32'hCAFEF00D, 1, -1);
        check("after_to_rdata", cap_rdata, 32'hCAFEF00D);
        access(0, 3'b101, 32'h306, 32'h0, 32'hBEEF0000, TO - 1, -1);
        check("ack_at_to_err", {31'd0, cap_err}, 32'd0);
        check("ack_at_to_rdata", cap_rdata, 32'h0000BEEF);

        access(0, 3'b010, 32'h400, 32'h0, 32'h0, 99, 1);
        access(0, 3'b010, 32'h404, 32'h0, 32'h13579BDF, 0, -1);
        check("post_rst_rdata", cap_rdata, 32'h13579BDF);

        for (int t = 0; t < 400; t++) begin
            we = 1'($urandom);
            if ($urandom_range(0, 7) == 0) op = 3'($urandom);
            else if (we) op = 3'($urandom_range(0, 2));
            else begin
                op = 3'($urandom_range(0, 4));
                if (op == 3) op = 3'b101;
            end
            addr = $urandom;
            if ($urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
            access(we, op, addr, $urandom, $urandom, $urandom_range(0, TO + 1),
                   ($urandom_range(0, 39) == 0) ? 0 : -1);
            if ($urandom_range(0, 2) == 0) idle_cycles($urandom_range(1, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rv_go_lsu.md
Name: rv_go_lsu

Overview:
Load/store unit between the RV_GO core's data-memory signals and a req/ack data bus. It latches one access (address, funct3 width op, write flag, store data), checks alignment, generates byte enables and lane-replicated store data, and waits for the bus acknowledge with a timeout. It returns sign- or zero-extended load data with a one-cycle done pulse, and drives a stall so the core holds its PC and request stable until the access retires.

Parameters:
TIMEOUT, 255, number of BUS-state cycles without bus_ack before the access retires with an error (valid range 1..65535)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
core_req  in  1  access request; held high by the core until core_done
core_we  in  1  1 = store, 0 = load (core mem_w)
core_op  in  3  RV32I funct3: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW
core_addr  in  32  byte address (core ALU result)
core_wdata  in  32  store data (rs2)
core_rdata  out  32  formatted load data; valid while core_done=1, 0 otherwise
core_done  out  1  one-cycle retire pulse
core_err  out  1  high with core_done if the access was misaligned, had an illegal op, or timed out
core_stall  out  1  combinational: (state==IDLE & core_req) | state==BUS
bus_req  out  1  bus request, registered
bus_we  out  1  bus write, registered
bus_addr  out  32  word address {addr[31:2],2'b00}, registered
bus_be  out  4  byte enables, registered
bus_wdata  out  32  lane-replicated store data, registered
bus_ack  in  1  single-cycle completion from the bus
bus_rdata  in  32  read word; sampled only in the cycle bus_ack=1

Behaviour:
- States: IDLE, BUS, DONE. Reset (rst=0, async) forces IDLE, all outputs 0, and the timeout counter to 0.
- IDLE, core_req=1: decode the request.
  - Illegal op: load op 011/110/111 or store op greater than 010.
  - Misaligned: halfword with addr[0]=1, or word with addr[1:0]!=0.
  - Illegal or misaligned: go to DONE with err latched to 1; no bus cycle is issued.
  - Otherwise: latch all bus_* outputs and the low address bits and op, set bus_req=1, clear the counter, and go to BUS.
- Byte enables (for loads and stores):
  - Byte: be = 4'b0001 << addr[1:0].
  - Half: be = addr[1] ? 4'b1100 : 4'b0011.
  - Word: be = 4'b1111.
- Store data lanes:
  - SB: {4{wdata[7:0]}}.
  - SH: {2{wdata[15:0]}}.
  - SW: wdata unchanged.
  - Loads: bus_wdata = 0.
- BUS: bus_* outputs are held stable and core_* inputs are ignored.
  - bus_ack=1: capture the formatted bus_rdata (loads) or 0 (stores), drop bus_req, go to DONE with err=0.
  - No ack: the counter increments. When the counter reaches TIMEOUT-1 with no ack, drop bus_req and go to DONE with err=1 and rdata=0.
  - An ack in the same cycle as the timeout wins (err=0).
- Load formatting: select the byte at addr[1:0] or the halfword at addr[1]. LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- DONE: core_done=1, core_err=err, and core_rdata is driven for exactly one cycle, then the block returns to IDLE.
  - core_req is not sampled in DONE.
  - A back-to-back request is accepted in the following IDLE cycle.
- bus_ack outside BUS is ignored.
- Latency: with an ack in the first BUS cycle, core_done rises 2 cycles after core_req is first seen in IDLE. An error-only path (misaligned or illegal) takes 1 cycle.
- Reset asserted mid-BUS: bus_req drops asynchronously, no core_done is issued, and the access is abandoned.

Test Plan:
- LW at 0x100, bus_rdata=0xDEADBEEF, ack in the 1st BUS cycle:
  - bus_addr=0x100, be=1111, bus_we=0.
  - core_done 2 cycles after req, rdata=0xDEADBEEF, err=0.
- Loads at 0x103 with bus_rdata=0x80xxxxxx:
  - LB → rdata=0xFFFFFF80.
  - LBU → 0x00000080.
  - LH at 0x102 with 0x8001xxxx → 0xFFFF8001, be=1100.
- SB at 0x201, wdata=0x12345678: bus_addr=0x200, be=0010, bus_wdata=0x78787878, bus_we=1. An ack 3 cycles late keeps all bus_* stable until the ack, then a done pulse follows.
- Misaligned and illegal access:
  - SW at 0x002 → done+err the next cycle, bus_req never rises.
  - LH at 0x001 → same.
  - Load op 011 → err.
- TIMEOUT=4, no ack: bus_req high for 4 cycles, then done+err=1, rdata=0. A further request is accepted normally afterwards.
- rst pulsed low during BUS: bus_req=0 immediately, no done. After release, a new LW completes normally.
